// File: rtl/i2c_seq_pkg.sv
// Shared state encodings and timeout-select codes for the I2C register sequencers.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_BUS  = 4'd1,
        S_CMD_WR    = 4'd2,
        S_ADDR      = 4'd3,
        S_CMD_RD    = 4'd4,
        S_RECV      = 4'd5,
        S_WAIT_FREE = 4'd6
    } seq_state_t;

    localparam logic [3:0] TSEL_OFF     = 4'd0;
    localparam logic [3:0] TSEL_DEFAULT = 4'd1;

    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_WAIT_BUS) || (s == S_WAIT_FREE);
    endfunction

endpackage

// File: rtl/i2c_seq_timer_ctl.sv
// Timeout timer run/restart control shared by the I2C sequencers.
// Latency: registered, one cycle; timer_start drops for a cycle on every state change.
module i2c_seq_timer_ctl
    import i2c_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  seq_state_t state_cur,
    input  seq_state_t state_nxt,
    output logic       timer_start
);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_start <= 1'b0;
        end else begin
            timer_start <= is_wait_state(state_nxt) && (state_nxt == state_cur);
        end
    end

endmodule

// File: rtl/i2c_read_reg.sv
// Reads READ_BYTES bytes from a device register: address write, repeated-start read(s).
// Latency: >= 6 cycles start-to-done; every master handshake holds valid until ready.
module i2c_read_reg
    import i2c_seq_pkg::*;
#(
    parameter int         READ_BYTES  = 1,
    parameter logic [3:0] TIMEOUT_SEL = TSEL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              dev_address,
    input  logic [7:0]              reg_address,
    input  logic                    start,
    output logic                    done,
    output logic [8*READ_BYTES-1:0] read_data,
    output logic                    message_failure,
    input  logic                    timer_exp,
    output logic                    timer_start,
    output logic [3:0]              timer_param,
    input  logic                    i2c_bus_busy,
    input  logic                    i2c_bus_active,
    input  logic                    i2c_bus_control,
    input  logic                    i2c_missed_ack,
    input  logic                    i2c_cmd_ready,
    output logic                    i2c_cmd_valid,
    output logic                    i2c_cmd_start,
    output logic                    i2c_cmd_read,
    output logic                    i2c_cmd_write_multiple,
    output logic                    i2c_cmd_stop,
    output logic [6:0]              i2c_dev_address,
    output logic [7:0]              i2c_data_in,
    output logic                    i2c_data_in_valid,
    output logic                    i2c_data_in_last,
    input  logic                    i2c_data_in_ready,
    input  logic [7:0]              i2c_data_out,
    input  logic                    i2c_data_out_valid,
    input  logic                    i2c_data_out_last,
    output logic                    i2c_data_out_ready,
    output logic                    i2c_control,
    input  logic                    i2c_relinquish,
    output logic [3:0]              state_out
);

    localparam int         DW       = 8 * READ_BYTES;
    localparam logic [1:0] LAST_IDX = 2'(READ_BYTES - 1);

    seq_state_t    state_q, state_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] read_data_d;
    logic          finish_ok, finish_fail;

    logic          done_d, fail_d, control_d;
    logic          cmd_valid_d, cmd_start_d, cmd_read_d, cmd_wm_d, cmd_stop_d;
    logic [6:0]    dev_addr_d;
    logic [7:0]    data_in_d;
    logic          data_in_valid_d, data_in_last_d, data_out_ready_d;
    logic [3:0]    timer_param_d;

    // Byte count already bounds the read; the master's last flag is redundant here.
    logic unused_data_out_last;
    assign unused_data_out_last = i2c_data_out_last;

    assign state_out = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dev_q   <= '0;
            reg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        read_data_d = read_data;
        finish_ok   = 1'b0;
        finish_fail = 1'b0;
        if (i2c_relinquish) begin
            state_d = S_IDLE;
        end else if (i2c_missed_ack && i2c_control) begin
            state_d     = S_IDLE;
            finish_fail = 1'b1;
        end else if (is_wait_state(state_q) && timer_exp) begin
            state_d     = S_IDLE;
            finish_fail = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    dev_d       = dev_address;
                    reg_d       = reg_address;
                    cnt_d       = '0;
                    read_data_d = '0;
                    state_d     = S_WAIT_BUS;
                end
                S_WAIT_BUS: if (!i2c_bus_busy && !i2c_bus_active) state_d = S_CMD_WR;
                S_CMD_WR:   if (i2c_cmd_valid && i2c_cmd_ready) state_d = S_ADDR;
                S_ADDR:     if (i2c_data_in_valid && i2c_data_in_ready) state_d = S_CMD_RD;
                S_CMD_RD:   if (i2c_cmd_valid && i2c_cmd_ready) state_d = S_RECV;
                S_RECV: if (i2c_data_out_valid && i2c_data_out_ready) begin
                    // First byte received ends up most significant.
                    read_data_d = DW'({read_data, i2c_data_out});
                    cnt_d       = cnt_q + 2'd1;
                    state_d     = (cnt_q == LAST_IDX) ? S_WAIT_FREE : S_CMD_RD;
                end
                S_WAIT_FREE: if (!i2c_bus_busy && !i2c_bus_control) begin
                    finish_ok = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they track state_q exactly.
    always_comb begin
        control_d        = (state_d != S_IDLE);
        done_d           = finish_ok | finish_fail;
        fail_d           = finish_fail;
        cmd_valid_d      = 1'b0;
        cmd_start_d      = 1'b0;
        cmd_read_d       = 1'b0;
        cmd_wm_d         = 1'b0;
        cmd_stop_d       = 1'b0;
        dev_addr_d       = control_d ? dev_d : 7'd0;
        data_in_d        = '0;
        data_in_valid_d  = 1'b0;
        data_in_last_d   = 1'b0;
        data_out_ready_d = 1'b0;
        timer_param_d    = TSEL_OFF;
        case (state_d)
            S_WAIT_BUS, S_WAIT_FREE: timer_param_d = TIMEOUT_SEL;
            S_CMD_WR: begin
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_wm_d    = 1'b1;
            end
            S_ADDR: begin
                data_in_d       = reg_d;
                data_in_valid_d = 1'b1;
                data_in_last_d  = 1'b1;
            end
            S_CMD_RD: begin
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_read_d  = 1'b1;
                cmd_stop_d  = (cnt_d == LAST_IDX);
            end
            S_RECV:  data_out_ready_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done                   <= 1'b0;
            message_failure        <= 1'b0;
            read_data              <= '0;
            timer_param            <= '0;
            i2c_control            <= 1'b0;
            i2c_cmd_valid          <= 1'b0;
            i2c_cmd_start          <= 1'b0;
            i2c_cmd_read           <= 1'b0;
            i2c_cmd_write_multiple <= 1'b0;
            i2c_cmd_stop           <= 1'b0;
            i2c_dev_address        <= '0;
            i2c_data_in            <= '0;
            i2c_data_in_valid      <= 1'b0;
            i2c_data_in_last       <= 1'b0;
            i2c_data_out_ready     <= 1'b0;
        end else begin
            done                   <= done_d;
            message_failure        <= fail_d;
            read_data              <= read_data_d;
            timer_param            <= timer_param_d;
            i2c_control            <= control_d;
            i2c_cmd_valid          <= cmd_valid_d;
            i2c_cmd_start          <= cmd_start_d;
            i2c_cmd_read           <= cmd_read_d;
            i2c_cmd_write_multiple <= cmd_wm_d;
            i2c_cmd_stop           <= cmd_stop_d;
            i2c_dev_address        <= dev_addr_d;
            i2c_data_in            <= data_in_d;
            i2c_data_in_valid      <= data_in_valid_d;
            i2c_data_in_last       <= data_in_last_d;
            i2c_data_out_ready     <= data_out_ready_d;
        end
    end

    i2c_seq_timer_ctl u_timer_ctl (
        .clk         (clk),
        .reset       (reset),
        .state_cur   (state_q),
        .state_nxt   (state_d),
        .timer_start (timer_start)
    );

endmodule

// File: doc/i2c_read_reg.md
Name: i2c_read_reg

Overview:
Sequencer that reads one or more bytes from an 8-bit register of an I2C device through the shared I2C master command/data interface. It performs a register-address write, then a repeated-start read, and returns the assembled data with a done/failure status. It sits beside the register-write sequencer on the same master and the same timeout timer. Bus ownership is arbitrated through i2c_control and i2c_relinquish.

Parameters:
READ_BYTES, 1, number of data bytes read per transaction (1..4); the first byte received is the most significant.
TIMEOUT_SEL, 4'd1, value driven on timer_param while waiting.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dev_address  in  7  target 7-bit device address
reg_address  in  8  register to read
start  in  1  one-cycle request; ignored unless in S_IDLE
done  out  1  one-cycle pulse when the transaction ends, with success or failure
read_data  out  8*READ_BYTES  assembled result; held until the next start
message_failure  out  1  one-cycle pulse, coincident with done, on failure
timer_exp  in  1  timeout expired
timer_start  out  1  held high to run the timer; low restarts it
timer_param  out  4  timeout select
i2c_bus_busy, i2c_bus_active, i2c_bus_control, i2c_missed_ack  in  1 each  master status
i2c_cmd_ready  in  1  master accepts a command
i2c_cmd_valid, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write_multiple, i2c_cmd_stop  out  1 each  command bits
i2c_dev_address  out  7  command address
i2c_data_in  out  8  byte to master (register address)
i2c_data_in_valid, i2c_data_in_last  out  1 each
i2c_data_in_ready  in  1
i2c_data_out  in  8  byte from master
i2c_data_out_valid, i2c_data_out_last  in  1 each
i2c_data_out_ready  out  1
i2c_control  out  1  high while this block owns the master
i2c_relinquish  in  1  force return to S_IDLE
state_out  out  4  debug

Behaviour:
- All outputs are registered. Reset values are 0 for every output, including read_data and state_out (S_IDLE = 0).
- Master-side outputs are driven 0 whenever i2c_control=0. No tristates; the top level ORs or muxes them with the writer's outputs.
- Abort priority: reset > i2c_relinquish > i2c_missed_ack > normal transition. Relinquish goes to S_IDLE silently with no done pulse. Missed_ack while i2c_control=1 pulses done and message_failure, then goes to S_IDLE.
- Any timer_exp while waiting pulses done and message_failure, then goes to S_IDLE.
- timer_start is 1 only in wait states and drops to 0 for at least one cycle on every state change.
- States:
  - S_IDLE: on start, latch dev_address/reg_address, clear the byte counter, set i2c_control=1, go to S_WAIT_BUS.
  - S_WAIT_BUS: when ~busy & ~active, go to S_CMD_WR. Else wait with the timer.
  - S_CMD_WR: cmd_valid=1 with start=1, write_multiple=1, stop=0. Hold until cmd_ready, then drop valid and go to S_ADDR.
  - S_ADDR: data_in=reg_address, valid=1, last=1. Hold until data_in_ready, then drop valid and go to S_CMD_RD.
  - S_CMD_RD: cmd_valid=1 with start=1 (repeated start), read=1, stop=1. If READ_BYTES>1, the command is reissued per byte; stop=1 only on the final byte. Hold until cmd_ready, then go to S_RECV.
  - S_RECV: data_out_ready=1. On data_out_valid: read_data <= {read_data[8*READ_BYTES-9:0], data_out} and the counter increments. When counter = READ_BYTES-1 at capture, go to S_WAIT_FREE; otherwise go to S_CMD_RD.
  - S_WAIT_FREE: when ~busy & ~bus_control, pulse done with failure=0, release i2c_control, go to S_IDLE. Else wait with the timer.
- Each valid/ready handshake transfers on the cycle both are high. Valid never drops before ready.
- read_data is cleared on start. After a failure it holds partial bytes and is undefined for use.
- start while busy is ignored. start in the same cycle as relinquish is ignored.
- Latency with an always-ready master and READ_BYTES=1: done no earlier than 6 cycles after start.

Decomposition:
- Shared package i2c_seq_pkg holds the state encodings and the timeout-select constants, used by both the reader and the writer.
- No sub-module is required. An optional tiny sub-module, i2c_seq_timer_ctl, generates the timer_start drop-on-state-change pulse and can be reused by the writer.

Test Plan:
- READ_BYTES=1, dev 0x21, reg 0x0A, master model returns 0x5C -> one write command with data 0x0A last=1, one read command with stop=1, read_data=0x5C, done pulse, message_failure=0, i2c_control back to 0.
- READ_BYTES=2, reg 0x3B, bytes 0x12 then 0x34 -> read_data=0x1234; stop=1 only on the second read command.
- Master asserts missed_ack during S_ADDR -> done=1 and message_failure=1 in the same cycle, state_out=0 next cycle, no read command issued.
- i2c_bus_busy held high, timer_exp after 50 cycles -> failure pulse; no cmd_valid ever asserted.
- i2c_relinquish asserted in S_RECV -> S_IDLE next cycle, no done pulse, all master outputs 0.
- start during an active transaction, and reset mid-S_CMD_RD -> no second transaction starts; all outputs return to 0 the cycle after reset.
